// File: rtl/predictor_trace_driver.sv
// Replays a latched trace of branch outcomes into a 2-bit predictor: query, then train,
// per branch, scoring the registered prediction against the actual outcome.
module predictor_trace_driver #(
  parameter int TRACE_LEN = 32,
  parameter int LEN_W     = $clog2(TRACE_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [TRACE_LEN-1:0] trace_bits,
  input  logic [LEN_W-1:0]     trace_len,
  output logic                 request,
  output logic                 result,
  output logic                 taken,
  input  logic                 prediction,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_W-1:0]     hit_count,
  output logic [LEN_W-1:0]     miss_count,
  output logic                 last_miss
);

  localparam int IDX_W = (TRACE_LEN > 1) ? $clog2(TRACE_LEN) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(TRACE_LEN);

  typedef enum logic [1:0] {IDLE, QUERY, TRAIN, DONE} state_e;

  state_e                 state_q, state_d;
  logic [TRACE_LEN-1:0]   trace_q, trace_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       idx_q, idx_d;
  logic [LEN_W-1:0]       hit_q, hit_d;
  logic [LEN_W-1:0]       miss_q, miss_d;
  logic                   last_miss_q, last_miss_d;
  logic                   request_q, request_d;
  logic                   result_q, result_d;
  logic                   taken_q, taken_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [LEN_W-1:0]       idx_inc;
  logic [LEN_W-1:0]       len_clamped;
  logic                   branch_bit;
  logic                   next_bit;

  assign idx_inc     = idx_q + LEN_W'(1);
  assign branch_bit  = trace_q[idx_q[IDX_W-1:0]];
  // Lookahead bit: outputs are registered, so taken for the next QUERY is loaded now.
  assign next_bit    = trace_q[idx_inc[IDX_W-1:0]];
  assign len_clamped = (trace_len > MAX_LEN) ? MAX_LEN : trace_len;

  always_comb begin
    state_d     = state_q;
    trace_d     = trace_q;
    len_d       = len_q;
    idx_d       = idx_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    last_miss_d = last_miss_q;
    request_d   = 1'b0;
    result_d    = 1'b0;
    taken_d     = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          trace_d     = trace_bits;
          len_d       = len_clamped;
          idx_d       = '0;
          hit_d       = '0;
          miss_d      = '0;
          last_miss_d = 1'b0;
          if (len_clamped == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = QUERY;
            result_d = 1'b1;
            taken_d  = trace_bits[0];
            busy_d   = 1'b1;
          end
        end
      end
      QUERY: begin
        state_d   = TRAIN;
        request_d = 1'b1;
        taken_d   = branch_bit;
        busy_d    = 1'b1;
      end
      TRAIN: begin
        if (prediction == branch_bit) begin
          hit_d       = hit_q + LEN_W'(1);
          last_miss_d = 1'b0;
        end else begin
          miss_d      = miss_q + LEN_W'(1);
          last_miss_d = 1'b1;
        end
        idx_d = idx_inc;
        if (idx_q == len_q - LEN_W'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d  = QUERY;
          result_d = 1'b1;
          taken_d  = next_bit;
          busy_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      trace_q     <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
      last_miss_q <= 1'b0;
      request_q   <= 1'b0;
      result_q    <= 1'b0;
      taken_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      trace_q     <= trace_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      last_miss_q <= last_miss_d;
      request_q   <= request_d;
      result_q    <= result_d;
      taken_q     <= taken_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign request    = request_q;
  assign result     = result_q;
  assign taken      = taken_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign last_miss  = last_miss_q;

endmodule

// File: tb/tb_predictor_trace_driver.sv
// Bench for predictor_trace_driver: a resetless 2-bit predictor stands in for the real one,
// and a saturating-counter model of the whole trace supplies the expected scores.
module tb_predictor_trace_driver;

  localparam int TL = 32;
  localparam int LW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [TL-1:0] trace_bits;
  logic [LW-1:0] trace_len;
  logic          request, result, taken, prediction, busy, done, last_miss;
  logic [LW-1:0] hit_count, miss_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  predictor_trace_driver #(.TRACE_LEN(TL), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .trace_bits(trace_bits),
    .trace_len(trace_len), .request(request), .result(result), .taken(taken),
    .prediction(prediction), .busy(busy), .done(done), .hit_count(hit_count),
    .miss_count(miss_count), .last_miss(last_miss)
  );

  // Predictor with no reset: prediction refreshed on query, counter trained on request.
  logic [1:0] pctr = 2'b00;
  logic       pred_reg = 1'b0;
  assign prediction = pred_reg;
  always @(posedge clk) begin
    if (result) pred_reg <= pctr[1];
    if (request) begin
      if (taken && pctr != 2'b11) pctr <= pctr + 2'b01;
      else if (!taken && pctr != 2'b00) pctr <= pctr - 2'b01;
    end
  end

  // Observations gathered during a run
  bit            capturing = 1'b0;
  int            n_query, n_train, obs_cyc;
  logic [TL-1:0] obs_taken;
  logic [LW-1:0] obs_hit, obs_miss, obs_hit_late;
  logic          obs_lm, obs_busy, obs_done_after, obs_stray;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      vectors++;
      if (request && result) begin
        miscompares++;
        $display("FAIL protocol at %0t: request=%b result=%b, required never both", $time, request, result);
      end
      if (capturing) begin
        if (result) n_query++;
        if (request) begin
          if (n_train < TL) obs_taken[n_train] = taken;
          n_train++;
        end
        if (request || result) begin
          vectors++;
          if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_during_run at %0t: busy=%b required 1", $time, busy);
          end
        end
      end
    end
  end

  // Reference: walk the trace through a saturating 2-bit counter.
  int model_ctr = 0;
  function automatic void ref_run(input logic [TL-1:0] bits, input int len, input int ctr_in,
                                  output int ctr_out, output int hits, output int misses,
                                  output logic lm);
    int c = ctr_in;
    hits = 0; misses = 0; lm = 1'b0;
    for (int i = 0; i < len; i++) begin
      logic t = bits[i];
      logic p = (c >= 2);
      if (p == t) begin hits++; lm = 1'b0; end
      else begin misses++; lm = 1'b1; end
      c = t ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
    end
    ctr_out = c;
  endfunction

  function automatic logic [TL-1:0] len_mask(input int n);
    logic [TL-1:0] m = '0;
    for (int i = 0; i < n && i < TL; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Drives one run; records what the DUT did (no comparisons here).
  task automatic run_trace(input logic [TL-1:0] bits, input int len, input int poke_cyc,
                           input bit poke_done);
    n_query = 0; n_train = 0; obs_taken = '0; capturing = 1'b1;
    @(negedge clk); start = 1'b1; trace_bits = bits; trace_len = LW'(len);
    @(negedge clk); start = 1'b0; obs_cyc = 1;
    while (done !== 1'b1 && obs_cyc < 200) begin
      if (obs_cyc == poke_cyc) begin start = 1'b1; trace_bits = ~bits; trace_len = LW'(3); end
      @(negedge clk); start = 1'b0; obs_cyc++;
    end
    capturing = 1'b0;
    obs_hit = hit_count; obs_miss = miss_count; obs_lm = last_miss; obs_busy = busy;
    start = poke_done;
    @(negedge clk); start = 1'b0; obs_done_after = done;
    obs_stray = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (request || result || busy || done) obs_stray = 1'b1;
    end
    obs_hit_late = hit_count;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; trace_bits = '0; trace_len = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({request, result, taken, busy, done, last_miss, hit_count, miss_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got req=%b res=%b tkn=%b busy=%b done=%b lm=%b hit=%0d miss=%0d, required all 0",
               request, result, taken, busy, done, last_miss, hit_count, miss_count);
    end
    rst_n = 1'b1;
    $display("reset: outputs checked");
  endtask

  task automatic test_directed(input string name, input logic [TL-1:0] bits, input int len);
    int eff, nc, eh, em; logic elm;
    eff = (len > TL) ? TL : len;
    ref_run(bits, eff, model_ctr, nc, eh, em, elm); model_ctr = nc;
    run_trace(bits, len, 0, 1'b0);
    vectors += 8;
    if (obs_cyc != 2 * eff + 1) begin miscompares++; $display("FAIL %s latency: got %0d cycles required %0d", name, obs_cyc, 2 * eff + 1); end
    if (obs_hit !== LW'(eh)) begin miscompares++; $display("FAIL %s hit: got %0d required %0d", name, obs_hit, eh); end
    if (obs_miss !== LW'(em)) begin miscompares++; $display("FAIL %s miss: got %0d required %0d", name, obs_miss, em); end
    if (obs_lm !== elm) begin miscompares++; $display("FAIL %s last_miss: got %b required %b", name, obs_lm, elm); end
    if (n_query != eff || n_train != eff) begin miscompares++; $display("FAIL %s pairs: got %0d queries %0d trains required %0d", name, n_query, n_train, eff); end
    if (obs_taken !== (bits & len_mask(eff))) begin miscompares++; $display("FAIL %s taken: got %h required %h", name, obs_taken, bits & len_mask(eff)); end
    if (obs_busy !== 1'b0 || obs_done_after !== 1'b0) begin miscompares++; $display("FAIL %s done_pulse: busy@done=%b done_next=%b required 0/0", name, obs_busy, obs_done_after); end
    if (obs_hit_late !== LW'(eh)) begin miscompares++; $display("FAIL %s hold: got %0d required %0d", name, obs_hit_late, eh); end
    $display("%s: len=%0d hit=%0d miss=%0d last_miss=%b cycles=%0d", name, len, obs_hit, obs_miss, obs_lm, obs_cyc);
  endtask

  task automatic test_all_taken();   test_directed("all_taken", 32'h0000_00FF, 8);   endtask
  task automatic test_not_taken();   test_directed("not_taken", 32'h0000_0000, 8);   endtask
  task automatic test_alternating(); test_directed("alternating", 32'h0000_0055, 8); endtask
  task automatic test_zero_len();    test_directed("zero_len", 32'hFFFF_FFFF, 0);    endtask
  task automatic test_clamp();       test_directed("clamp", $urandom, 40);           endtask

  task automatic test_busy_start();
    int nc, eh, em; logic elm; logic [TL-1:0] bits;
    bits = $urandom;
    ref_run(bits, 10, model_ctr, nc, eh, em, elm); model_ctr = nc;
    run_trace(bits, 10, 5, 1'b0);
    vectors += 3;
    if (obs_cyc != 21) begin miscompares++; $display("FAIL busy_start latency: got %0d required 21", obs_cyc); end
    if (obs_hit !== LW'(eh) || obs_miss !== LW'(em)) begin miscompares++; $display("FAIL busy_start counts: got %0d/%0d required %0d/%0d", obs_hit, obs_miss, eh, em); end
    if (obs_taken !== (bits & len_mask(10))) begin miscompares++; $display("FAIL busy_start taken: got %h required %h", obs_taken, bits & len_mask(10)); end
    $display("busy_start: hit=%0d miss=%0d cycles=%0d", obs_hit, obs_miss, obs_cyc);
  endtask

  task automatic test_done_start();
    int nc, eh, em; logic elm; logic [TL-1:0] bits;
    bits = $urandom;
    ref_run(bits, 4, model_ctr, nc, eh, em, elm); model_ctr = nc;
    run_trace(bits, 4, 0, 1'b1);
    vectors += 3;
    if (obs_cyc != 9) begin miscompares++; $display("FAIL done_start latency: got %0d required 9", obs_cyc); end
    if (obs_stray !== 1'b0) begin miscompares++; $display("FAIL done_start ignored: activity=%b required 0", obs_stray); end
    if (obs_hit_late !== LW'(eh)) begin miscompares++; $display("FAIL done_start hold: got %0d required %0d", obs_hit_late, eh); end
    $display("done_start: hit=%0d miss=%0d idle_activity=%b", obs_hit, obs_miss, obs_stray);
  endtask

  task automatic test_reset_midrun();
    int nc, eh, em; logic elm; logic [TL-1:0] bits;
    bits = $urandom;
    // Only the first two branches finish training before the abort.
    ref_run(bits, 2, model_ctr, nc, eh, em, elm); model_ctr = nc;
    @(negedge clk); start = 1'b1; trace_bits = bits; trace_len = LW'(8);
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    vectors += 3;
    if (request !== 1'b1) begin miscompares++; $display("FAIL midrun third_train: request=%b required 1", request); end
    if (hit_count !== LW'(eh) || miss_count !== LW'(em)) begin miscompares++; $display("FAIL midrun partial: got %0d/%0d required %0d/%0d", hit_count, miss_count, eh, em); end
    #2 rst_n = 1'b0;
    #1;
    if ({request, result, taken, busy, done, last_miss, hit_count, miss_count} !== '0) begin
      miscompares++;
      $display("FAIL midrun async_reset: req=%b res=%b busy=%b hit=%0d miss=%0d required all 0", request, result, busy, hit_count, miss_count);
    end
    @(negedge clk); rst_n = 1'b1;
    $display("reset_midrun: aborted at third train");
    test_directed("after_reset", $urandom, 8);
  endtask

  task automatic test_random();
    for (int r = 0; r < 16; r++) begin
      logic [TL-1:0] bits = $urandom;
      int len = $urandom_range(0, 40);
      test_directed("random", bits, len);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_all_taken();
    test_not_taken();
    test_alternating();
    test_zero_len();
    test_clamp();
    test_busy_start();
    test_done_start();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
